// File: rtl/source_gen.sv
// Packet traffic source: emits len_i beats of counter or LFSR payload
// over valid/ready, with optional idle gap cycles between beats.
module source_gen #(
   parameter int unsigned GAP  = 1,
   parameter logic [7:0]  SEED = 8'h01
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       start_i,
   input  logic       mode_i,
   input  logic [7:0] len_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [7:0] data_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [8:0] count_o
);

   // An all-zero LFSR would lock up, so fall back to 01
   localparam logic [7:0] LSEED  = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [7:0] LGAP   = 8'(GAP);
   localparam logic [7:0] LGAPM1 = LGAP - 8'd1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
   } state_t;

   state_t     r_state;
   state_t     w_state;
   logic [8:0] r_rem;
   logic [8:0] w_rem;
   logic [7:0] r_gap_cnt;
   logic [7:0] w_gap_cnt;
   logic       r_mode;
   logic       w_mode;
   logic [7:0] r_data;
   logic [7:0] w_data;
   logic       r_valid;
   logic       w_valid;
   logic       r_busy;
   logic       w_busy;
   logic       r_done;
   logic       w_done;
   logic [8:0] r_count;
   logic [8:0] w_count;
   logic       w_xfer;
   logic [7:0] w_next;

   // Payload successor; data_o doubles as counter and LFSR state
   function automatic logic [7:0] f_next(
      input logic       mode,
      input logic [7:0] d
   );
      if (mode)
         f_next = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
      else
         f_next = d + 8'd1;
   endfunction

   assign w_xfer = r_valid & ready_i;
   assign w_next = f_next(r_mode, r_data);

   // State and all registered outputs
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state   <= S_IDLE;
         r_rem     <= '0;
         r_gap_cnt <= '0;
         r_mode    <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state   <= w_state;
         r_rem     <= w_rem;
         r_gap_cnt <= w_gap_cnt;
         r_mode    <= w_mode;
         r_data    <= w_data;
         r_valid   <= w_valid;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_count   <= w_count;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      w_state   = r_state;
      w_rem     = r_rem;
      w_gap_cnt = r_gap_cnt;
      w_mode    = r_mode;
      w_data    = r_data;
      w_valid   = r_valid;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_count   = r_count;
      unique case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state = S_SEND;
               w_mode  = mode_i;
               w_rem   = (len_i == 8'd0) ? 9'd256 : {1'b0, len_i};
               w_count = '0;
               w_data  = mode_i ? LSEED : 8'h00;
               w_valid = 1'b1;
               w_busy  = 1'b1;
            end
         end
         S_SEND: begin
            if (w_xfer) begin
               w_count = r_count + 9'd1;
               w_rem   = r_rem - 9'd1;
               if (r_rem == 9'd1) begin
                  w_state = S_IDLE;
                  w_valid = 1'b0;
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
               end else if (LGAP == 8'd0) begin
                  w_data = w_next;
               end else begin
                  w_state   = S_GAP;
                  w_valid   = 1'b0;
                  w_gap_cnt = LGAPM1;
                  w_data    = w_next;
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt == 8'd0) begin
               w_state = S_SEND;
               w_valid = 1'b1;
            end else begin
               w_gap_cnt = r_gap_cnt - 8'd1;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_valid = 1'b0;
            w_busy  = 1'b0;
         end
      endcase
   end

   assign valid_o = r_valid;
   assign data_o  = r_data;
   assign busy_o  = r_busy;
   assign done_o  = r_done;
   assign count_o = r_count;

endmodule

// File: tb/tb_source_gen.sv
// Scoreboard bench for source_gen: two instances (GAP=0 and GAP=2)
// share clock, reset and handshake inputs; each has its own start.
module tb_source_gen;

   logic       clk;
   logic       rstn;
   logic       start0;
   logic       start2;
   logic       mode;
   logic [7:0] len;
   logic       ready;

   logic       v0, v2;
   logic [7:0] d0, d2;
   logic       b0, b2;
   logic       dn0, dn2;
   logic [8:0] c0, c2;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   bit         vtrace[$];
   int         dones;
   int         done_cyc;
   int         viol;
   bit         tmo;
   logic [8:0] fin_cnt;

   source_gen #(.GAP(0), .SEED(8'h01)) u_g0 (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .start_i (start0),
      .mode_i  (mode),
      .len_i   (len),
      .ready_i (ready),
      .valid_o (v0),
      .data_o  (d0),
      .busy_o  (b0),
      .done_o  (dn0),
      .count_o (c0)
   );

   source_gen #(.GAP(2), .SEED(8'h01)) u_g2 (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .start_i (start2),
      .mode_i  (mode),
      .len_i   (len),
      .ready_i (ready),
      .valid_o (v2),
      .data_o  (d2),
      .busy_o  (b2),
      .done_o  (dn2),
      .count_o (c2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_start(input int sel, input logic m,
                           input logic [7:0] l);
      @(posedge clk); #1;
      mode = m;
      len  = l;
      if (sel == 0) start0 = 1'b1;
      else          start2 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start2 = 1'b0;
   endtask

   // Push the expected payload of one packet
   task automatic push_packet(input logic m, input int n);
      logic [7:0] d;
      d = m ? 8'h01 : 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(d);
         if (m) d = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
         else   d = d + 8'd1;
      end
   endtask

   // Runs the handshake, records beats/valid trace/done; no judging here
   task automatic collect(input int sel, input int maxcyc,
                          input int rmode, input int pulse_c);
      int         rw;
      bit         hold;
      bit         xf;
      logic [7:0] hd;
      logic       v, dn;
      logic [7:0] d;
      logic [8:0] cn;
      obs_q.delete();
      vtrace.delete();
      dones = 0; done_cyc = -1; viol = 0;
      rw = 2; hold = 0; hd = '0;
      for (int c = 0; c < maxcyc; c++) begin
         @(negedge clk);
         if (sel == 0) begin v = v0; d = d0; dn = dn0; cn = c0; end
         else          begin v = v2; d = d2; dn = dn2; cn = c2; end
         vtrace.push_back(v);
         xf = v && ready;
         if (hold && (!v || d !== hd)) viol++;
         hold = v && !ready;
         hd = d;
         if (xf) obs_q.push_back(d);
         fin_cnt = cn;
         if (dn) begin
            dones++;
            done_cyc = c;
            break;
         end
         @(posedge clk); #1;
         case (rmode)
            1: ready = !((c + 1) >= 2 && (c + 1) <= 4);
            2: begin
               if (xf) begin ready = 1'b0; rw = 2; end
               else if (rw > 1) rw--;
               else ready = 1'b1;
            end
            default: ready = 1'b1;
         endcase
         if (c + 1 == pulse_c) begin
            mode = 1'b1; len = 8'd3;
            if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
         end else begin
            start0 = 1'b0; start2 = 1'b0;
         end
      end
      tmo = (dones == 0);
   endtask

   task automatic test_reset;
      rstn = 1'b0; start0 = 0; start2 = 0;
      mode = 0; len = 0; ready = 0;
      #12;
      checks++;
      if ({v0, d0, b0, dn0, c0} !== 20'h0) begin
         errors++;
         $display("FAIL reset_g0 got %h want 0", {v0, d0, b0, dn0, c0});
      end
      checks++;
      if ({v2, d2, b2, dn2, c2} !== 20'h0) begin
         errors++;
         $display("FAIL reset_g2 got %h want 0", {v2, d2, b2, dn2, c2});
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_counter;
      ready = 1'b1;
      exp_q.delete();
      push_packet(1'b0, 4);
      do_start(0, 1'b0, 8'd4);
      collect(0, 20, 0, -1);
      checks++;
      if (tmo) begin errors++; $display("FAIL cnt_timeout no done"); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL cnt_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL cnt_data got %h want %h", o, e);
         end
      end
      checks++;
      if (vtrace.size() != 5 || vtrace[0] !== 1 || vtrace[1] !== 1 ||
          vtrace[2] !== 1 || vtrace[3] !== 1 || vtrace[4] !== 0) begin
         errors++;
         $display("FAIL cnt_valid trace size %0d want 11110", vtrace.size());
      end
      checks++;
      if (done_cyc != 4) begin
         errors++;
         $display("FAIL cnt_done_cyc got %0d want 4", done_cyc);
      end
      checks++;
      if (fin_cnt !== 9'd4) begin
         errors++;
         $display("FAIL cnt_count got %0d want 4", fin_cnt);
      end
   endtask

   task automatic test_backpressure;
      ready = 1'b1;
      exp_q.delete();
      push_packet(1'b0, 6);
      do_start(0, 1'b0, 8'd6);
      collect(0, 40, 1, -1);
      checks++;
      if (tmo || viol != 0) begin
         errors++;
         $display("FAIL bp_hold viol %0d tmo %0d want 0 0", viol, tmo);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL bp_data got %h want %h", o, e);
         end
      end
      ready = 1'b0;
      exp_q.delete();
      push_packet(1'b0, 5);
      do_start(0, 1'b0, 8'd5);
      collect(0, 60, 2, -1);
      checks++;
      if (tmo || viol != 0 || fin_cnt !== 9'd5) begin
         errors++;
         $display("FAIL sink_hold viol %0d tmo %0d cnt %0d want 0 0 5",
                  viol, tmo, fin_cnt);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL sink_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL sink_data got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_lfsr;
      ready = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h04); exp_q.push_back(8'h08);
      exp_q.push_back(8'h11); exp_q.push_back(8'h23);
      do_start(0, 1'b1, 8'd6);
      collect(0, 20, 0, -1);
      checks++;
      if (tmo || obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL lfsr_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL lfsr_data got %h want %h", o, e);
         end
      end
      exp_q.delete();
      exp_q.push_back(8'h01);
      do_start(0, 1'b1, 8'd1);
      collect(0, 10, 0, -1);
      checks++;
      if (tmo || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL lfsr_restart got %0d beats first %h want 1 beat 01",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
      end
   endtask

   task automatic test_gap;
      bit want[8];
      want = '{1, 0, 0, 1, 0, 0, 1, 0};
      ready = 1'b1;
      exp_q.delete();
      push_packet(1'b0, 3);
      do_start(1, 1'b0, 8'd3);
      collect(1, 30, 0, -1);
      checks++;
      if (tmo || vtrace.size() != 8) begin
         errors++;
         $display("FAIL gap_len trace %0d tmo %0d want 8 0", vtrace.size(), tmo);
      end
      for (int i = 0; i < 8 && i < vtrace.size(); i++) begin
         checks++;
         if (vtrace[i] !== want[i]) begin
            errors++;
            $display("FAIL gap_valid cyc %0d got %0d want %0d",
                     i, vtrace[i], want[i]);
         end
      end
      checks++;
      if (done_cyc != 7) begin
         errors++;
         $display("FAIL gap_done_cyc got %0d want 7", done_cyc);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL gap_data got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_len256;
      int bad;
      ready = 1'b1;
      exp_q.delete();
      push_packet(1'b0, 256);
      do_start(0, 1'b0, 8'd0);
      collect(0, 300, 0, 100);
      checks++;
      if (tmo || obs_q.size() != 256) begin
         errors++;
         $display("FAIL l256_nbeats got %0d want 256", obs_q.size());
      end
      bad = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [7:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         if (o !== e) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL l256_data got %0d wrong beats want 0", bad);
      end
      checks++;
      if (fin_cnt !== 9'h100 || dones != 1) begin
         errors++;
         $display("FAIL l256_count got %h dones %0d want 100 1", fin_cnt, dones);
      end
      @(negedge clk);
      checks++;
      if (dn0 !== 1'b0 || b0 !== 1'b0) begin
         errors++;
         $display("FAIL l256_after done %b busy %b want 0 0", dn0, b0);
      end
   endtask

   task automatic test_mid_reset;
      int nd;
      ready = 1'b1;
      do_start(0, 1'b0, 8'd5);
      collect(0, 2, 0, -1);
      checks++;
      if (obs_q.size() != 2 || obs_q[0] !== 8'h00 || obs_q[1] !== 8'h01) begin
         errors++;
         $display("FAIL mrst_pre got %0d beats want 2 (00 01)", obs_q.size());
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({v0, b0, dn0, c0} !== 12'h0) begin
         errors++;
         $display("FAIL mrst_async got v%b b%b d%b c%0d want 0",
                  v0, b0, dn0, c0);
      end
      nd = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (dn0) nd++;
      end
      rstn = 1'b1;
      @(negedge clk);
      if (dn0) nd++;
      checks++;
      if (nd != 0) begin
         errors++;
         $display("FAIL mrst_done got %0d pulses want 0", nd);
      end
      do_start(0, 1'b0, 8'd1);
      collect(0, 10, 0, -1);
      checks++;
      if (tmo || obs_q.size() != 1 || obs_q[0] !== 8'h00) begin
         errors++;
         $display("FAIL mrst_restart got %0d beats first %h want 1 beat 00",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
      end
   endtask

   initial begin
      test_reset();
      test_counter();
      test_backpressure();
      test_lfsr();
      test_gap();
      test_len256();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
